hamming_fitness: RTL and testbench
==================================

HAMMING_FITNESS -- requirements
Module: hamming_fitness

Interface
REQ-001 Parameter IndividualWidth, default 32, width of the candidate individual and of the target.
REQ-002 Parameter ErrorWidth, default 32, width of the fitness error result.
REQ-003 Parameter BitsPerCycle, default 1, individual bits compared per BUSY cycle.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 fitnessStart  input  1  request from the GA; its rising edge starts one evaluation.
REQ-007 fitnessIndividual  input  IndividualWidth  candidate to score; sampled only at the accepted start.
REQ-008 target  input  IndividualWidth  reference pattern; sampled only at the accepted start.
REQ-009 fitnessFinish  output  1  one-cycle pulse; fitnessError is valid from this cycle onward.
REQ-010 fitnessError  output  ErrorWidth  Hamming distance between the sampled fitnessIndividual and target.
REQ-011 busy  output  1  high while state is BUSY or DONE.

Function
REQ-012 IndividualWidth SHALL be a multiple of BitsPerCycle; ErrorWidth SHALL be at least clog2(IndividualWidth+1). Both are elaboration-time checks, with no runtime handling.
REQ-013 The block SHALL register fitnessStart into startPrev every cycle. An accepted start is fitnessStart=1, startPrev=0 and state=IDLE.
REQ-014 States SHALL be IDLE, BUSY and DONE.
- IDLE to BUSY on an accepted start.
- BUSY to DONE after L = IndividualWidth/BitsPerCycle BUSY cycles.
- DONE to IDLE unconditionally after one cycle.
REQ-015 On an accepted start (edge 0), the block SHALL:
- load shift register diff = fitnessIndividual XOR target;
- clear the accumulator;
- load the counter with L.
REQ-016 Each BUSY edge k (k = 1..L), the block SHALL:
- add popcount(diff[BitsPerCycle-1:0]) to the accumulator;
- shift diff right by BitsPerCycle;
- decrement the counter.
REQ-017 At edge L, the block SHALL load fitnessError with the final accumulator, zero-extended to ErrorWidth, and enter DONE. fitnessFinish SHALL be high from edge L to edge L+1, i.e. exactly one cycle.
REQ-018 fitnessError SHALL hold its value until the next DONE entry or reset; it SHALL NOT change during IDLE or BUSY.
REQ-019 A rising edge of fitnessStart during BUSY or DONE SHALL be ignored, not queued.
- fitnessStart held high across DONE into IDLE SHALL NOT start a new evaluation; a fresh 0-to-1 transition is required.
REQ-020 Changes on fitnessIndividual or target after edge 0 SHALL NOT affect the result.
REQ-021 Latency SHALL be fixed: fitnessFinish rises exactly L edges after the accepting edge, independent of data.
- Defaults: L=32.
- BitsPerCycle=4: L=8.
REQ-022 Back-to-back evaluations: the earliest next accepted start SHALL be the edge at which the state returns to IDLE plus one, given a fresh rising edge.

Reset
REQ-023 With rst=1 at a rising edge, the block SHALL set:
- state to IDLE;
- fitnessFinish, fitnessError, busy, the accumulator, diff, the counter and startPrev to 0.
REQ-024 rst SHALL take priority over every other condition, including mid-BUSY and DONE. An in-flight evaluation is discarded with no fitnessFinish pulse.
REQ-025 Because startPrev resets to 0, fitnessStart=1 on the first cycle after rst deasserts SHALL count as an accepted start.

Verification
REQ-026 Defaults; target=0xEEEEEEEE, individual=0xEEEEEEEE; pulse start -> fitnessFinish one cycle exactly 32 edges after the accepting edge, fitnessError=0.
REQ-027 Defaults; target=0xEEEEEEEE; individual=0x00000000 -> error=24; individual=0x11111111 -> error=32; run both back-to-back, and fitnessError holds 24 until the second DONE.
REQ-028 BitsPerCycle=4; target=0xEEEEEEEE, individual=0xFFFFFFFF -> fitnessFinish 8 edges after the accepting edge, fitnessError=8.
REQ-029 Defaults; start accepted, then change individual and target to 0 at edge 3 and toggle fitnessStart 0-1 at edge 10 -> a single finish at edge 32 with the originally sampled error; the second edge is ignored.
REQ-030 Defaults; assert rst at edge 15 of BUSY -> no fitnessFinish, fitnessError=0, busy=0. A new start after rst deasserts completes normally with latency 32.
REQ-031 Defaults; hold fitnessStart high through a full evaluation -> exactly one fitnessFinish; no second evaluation until fitnessStart falls and rises again.

Source files
------------

// File: rtl/hamming_fitness.sv
// hamming_fitness: serial Hamming-distance fitness evaluator for a GA.
// Scores BitsPerCycle bits per cycle with a fixed, data-independent latency.
module hamming_fitness #(
   parameter int IndividualWidth = 32,
   parameter int ErrorWidth      = 32,
   parameter int BitsPerCycle    = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fitnessStart,
   input  logic [IndividualWidth-1:0] fitnessIndividual,
   input  logic [IndividualWidth-1:0] target,
   output logic                       fitnessFinish,
   output logic [ErrorWidth-1:0]      fitnessError,
   output logic                       busy
);
   localparam int unsigned NumSteps   = IndividualWidth / BitsPerCycle;
   localparam int unsigned LaneCount  = BitsPerCycle;
   localparam int unsigned CountWidth = $clog2(NumSteps + 1);
   localparam int unsigned AccWidth   = $clog2(IndividualWidth + 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBusy = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   if ((IndividualWidth % BitsPerCycle) != 0) begin : gWidthCheck
      $error("IndividualWidth must be a multiple of BitsPerCycle");
   end
   if (ErrorWidth < int'(AccWidth)) begin : gErrorWidthCheck
      $error("ErrorWidth too narrow for the maximum Hamming distance");
   end

   logic [1:0]                 state;
   logic                       startPrev;
   logic                       startAccepted;
   logic [IndividualWidth-1:0] diff;
   logic [AccWidth-1:0]        acc;
   logic [AccWidth-1:0]        accNext;
   logic [CountWidth-1:0]      count;

   assign startAccepted = fitnessStart && !startPrev && (state == StIdle);
   assign busy          = (state != StIdle);

   // Popcount of the low lane of the shift register folded into the running sum.
   always_comb begin
      accNext = acc;
      for (int unsigned i = 0; i < LaneCount; i++) begin
         accNext = accNext + AccWidth'(diff[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= StIdle;
         startPrev     <= 1'b0;
         diff          <= '0;
         acc           <= '0;
         count         <= '0;
         fitnessFinish <= 1'b0;
         fitnessError  <= '0;
      end else begin
         startPrev     <= fitnessStart;
         fitnessFinish <= 1'b0;
         case (state)
            StIdle: begin
               if (startAccepted) begin
                  diff  <= fitnessIndividual ^ target;
                  acc   <= '0;
                  count <= CountWidth'(NumSteps);
                  state <= StBusy;
               end
            end
            StBusy: begin
               acc   <= accNext;
               diff  <= diff >> BitsPerCycle;
               count <= count - CountWidth'(1);
               // Last lane: publish the sum including this cycle's contribution.
               if (count == CountWidth'(1)) begin
                  fitnessError  <= ErrorWidth'(accNext);
                  fitnessFinish <= 1'b1;
                  state         <= StDone;
               end
            end
            StDone:  state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_hamming_fitness.sv
// Self-checking bench for hamming_fitness: directed scenarios plus random
// operands scored against a $countones reference, on 1- and 4-bit-lane instances.
module tb_hamming_fitness;
   logic        clk = 1'b0;
   logic        rst;
   logic        start1, start4;
   logic [31:0] fitnessIndividual, target;
   logic        fin1, fin4, busy1, busy4;
   logic [31:0] err1, err4;

   int nChecks = 0;
   int nErrors = 0;
   int lastErr [2];

   always #5 clk = ~clk;

   hamming_fitness #(.IndividualWidth(32), .ErrorWidth(32), .BitsPerCycle(1)) dut (
      .clk(clk), .rst(rst), .fitnessStart(start1),
      .fitnessIndividual(fitnessIndividual), .target(target),
      .fitnessFinish(fin1), .fitnessError(err1), .busy(busy1));

   hamming_fitness #(.IndividualWidth(32), .ErrorWidth(32), .BitsPerCycle(4)) dut4 (
      .clk(clk), .rst(rst), .fitnessStart(start4),
      .fitnessIndividual(fitnessIndividual), .target(target),
      .fitnessFinish(fin4), .fitnessError(err4), .busy(busy4));

   task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic getFin(input int sel);
      return (sel != 0) ? fin4 : fin1;
   endfunction
   function automatic logic getBusy(input int sel);
      return (sel != 0) ? busy4 : busy1;
   endfunction
   function automatic logic [31:0] getErr(input int sel);
      return (sel != 0) ? err4 : err1;
   endfunction

   task automatic setStart(input int sel, input logic v);
      if (sel != 0) start4 = v;
      else start1 = v;
   endtask

   // Runs from just after the accepting edge. mode 0: start pulsed; 1: start held
   // high throughout; 2: operands zeroed at edge 3 and a second rising edge at 10.
   task automatic runBody(input int sel, input int expErr, input int mode, input string tag);
      int  lenL   = (sel != 0) ? 8 : 32;
      int  lat    = 0;
      bit  held   = 1'b1;
      bit  busyOk = 1'b1;
      bit  quiet  = 1'b1;
      for (int k = 1; k <= 100 && lat == 0; k++) begin
         @(negedge clk);
         if (k == 1 && mode == 0) setStart(sel, 1'b0);
         if (k == 3) begin
            if (mode == 2) begin
               fitnessIndividual = '0;
               target            = '0;
            end else begin
               fitnessIndividual = $urandom;
               target            = $urandom;
            end
         end
         if (mode == 2 && k == 9)  setStart(sel, 1'b0);
         if (mode == 2 && k == 10) setStart(sel, 1'b1);
         @(posedge clk); #1;
         if (getFin(sel)) lat = k;
         else begin
            if (getErr(sel) != 32'(lastErr[sel])) held = 1'b0;
            if (!getBusy(sel)) busyOk = 1'b0;
         end
      end
      checkValue({tag, " latency"}, 64'(lat), 64'(lenL));
      checkValue({tag, " error"}, 64'(getErr(sel)), 64'(expErr));
      checkValue({tag, " errorHeld"}, 64'(held), 64'd1);
      checkValue({tag, " busyDuring"}, 64'(busyOk), 64'd1);
      checkValue({tag, " busyAtFinish"}, 64'(getBusy(sel)), 64'd1);
      lastErr[sel] = expErr;
      @(posedge clk); #1;
      checkValue({tag, " finishOneCycle"}, 64'(getFin(sel)), 64'd0);
      checkValue({tag, " busyAfter"}, 64'(getBusy(sel)), 64'd0);
      checkValue({tag, " errorKept"}, 64'(getErr(sel)), 64'(expErr));
      if (mode != 0) begin
         for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (getFin(sel) || getBusy(sel)) quiet = 1'b0;
         end
         checkValue({tag, " noRestart"}, 64'(quiet), 64'd1);
         @(negedge clk);
         setStart(sel, 1'b0);
         @(posedge clk); #1;
      end
   endtask

   task automatic runEval(input int sel, input logic [31:0] ind, input logic [31:0] tgt,
                          input int mode, input string tag);
      int expErr = $countones(ind ^ tgt);
      @(negedge clk);
      fitnessIndividual = ind;
      target            = tgt;
      setStart(sel, 1'b1);
      @(posedge clk);
      runBody(sel, expErr, mode, tag);
   endtask

   initial begin
      bit quietRst = 1'b1;
      int expErr;
      logic [31:0] a, b;
      rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
      fitnessIndividual = '0; target = '0;
      lastErr[0] = 0; lastErr[1] = 0;
      repeat (2) @(posedge clk);
      #1;
      checkValue("reset finish", 64'(fin1), 64'd0);
      checkValue("reset error", 64'(err1), 64'd0);
      checkValue("reset busy", 64'(busy1), 64'd0);
      checkValue("reset busy4", 64'(busy4), 64'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);

      runEval(0, 32'hEEEEEEEE, 32'hEEEEEEEE, 0, "equal");
      runEval(0, 32'h00000000, 32'hEEEEEEEE, 0, "b2bFirst");
      runEval(0, 32'h11111111, 32'hEEEEEEEE, 0, "b2bSecond");
      runEval(1, 32'hFFFFFFFF, 32'hEEEEEEEE, 0, "lanes4");
      runEval(0, 32'h12345678, 32'hEEEEEEEE, 2, "ignoreEdge");
      runEval(0, 32'hA5A5A5A5, 32'h0F0F0F0F, 1, "holdStart");

      // Reset in the middle of BUSY, with start held high through the reset.
      a = 32'hDEADBEEF; b = 32'h01234567;
      @(negedge clk);
      fitnessIndividual = a; target = b; start1 = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 1) start1 = 1'b0;
         @(posedge clk); #1;
         if (fin1) quietRst = 1'b0;
      end
      @(negedge clk);
      rst = 1'b1; start1 = 1'b1;
      @(posedge clk); #1;
      checkValue("midRst noFinish", 64'(quietRst | fin1), 64'd1);
      checkValue("midRst finish", 64'(fin1), 64'd0);
      checkValue("midRst error", 64'(err1), 64'd0);
      checkValue("midRst busy", 64'(busy1), 64'd0);
      lastErr[0] = 0; lastErr[1] = 0;
      @(posedge clk);
      a = 32'hCAFEF00D; b = 32'h0000FFFF;
      expErr = $countones(a ^ b);
      @(negedge clk);
      rst = 1'b0; fitnessIndividual = a; target = b;
      @(posedge clk);
      runBody(0, expErr, 0, "rstRestart");

      for (int n = 0; n < 8; n++) begin
         runEval(0, $urandom, $urandom, 0, "rand1");
         runEval(1, $urandom, $urandom, 0, "rand4");
      end

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end
endmodule
